// File: rtl/fa_pkg.sv
// Shared constants and FSM encoding for the feature-map pipeline (dma, win_buf, conv_3x3).
// Also carries the small stride-alignment helper used by the window buffer.
package fa_pkg;

    localparam int FA_DATA_W = 16;
    localparam int FA_MAX_W  = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } wb_state_e;

    // (x-2) mod S == 0 for S in {1,2}: always true at S=1, otherwise x must be even.
    function automatic logic stride_hit(input logic [1:0] stride, input logic lsb);
        return (stride == 2'd1) || !lsb;
    endfunction

endpackage

// File: rtl/line_ram.sv
// Single-clock simple dual-port line buffer with synchronous read.
// A read and a write to the same address in one cycle returns the old contents.
module line_ram #(
    parameter int  DATA_W = 16,
    parameter int  DEPTH  = 256,
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        rdata_q <= mem[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/win_buf.sv
// Raster-order pixel stream to 3x3 sliding-window converter with stride 1 or 2.
// Two line RAMs hold the previous two rows; a 3x3 register array forms the window.
module win_buf
    import fa_pkg::*;
#(
    parameter int  DATA_W = FA_DATA_W,
    parameter int  MAX_W  = FA_MAX_W,
    localparam int WW     = $clog2(MAX_W + 1),
    localparam int AW     = (MAX_W > 1) ? $clog2(MAX_W) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [WW-1:0]       cfg_width,
    input  logic [15:0]         cfg_height,
    input  logic [1:0]          cfg_stride,
    input  logic                din_valid,
    output logic                din_ready,
    input  logic [DATA_W-1:0]   din_data,
    output logic                win_valid,
    input  logic                win_ready,
    output logic [9*DATA_W-1:0] win_data,
    output logic                busy,
    output logic                done,
    output logic                cfg_err,
    output wb_state_e           dbg_state
);

    localparam logic [WW-1:0] W_ONE = WW'(1);
    localparam logic [WW-1:0] W_TWO = WW'(2);
    localparam logic [WW-1:0] W_MIN = WW'(3);
    localparam logic [WW-1:0] W_MAX = WW'(MAX_W);

    // Handshakes: a beat moves on a port in any cycle where its valid and ready are both high;
    // win_valid/win_data never change while win_valid is high and win_ready is low.

    wb_state_e            state_q, state_d;
    logic [WW-1:0]        width_q, width_d;
    logic [WW-1:0]        col_q, col_d;
    logic [15:0]          height_q, height_d;
    logic [15:0]          row_q, row_d;
    logic [1:0]           stride_q, stride_d;
    logic                 cfg_err_q, cfg_err_d;
    logic                 win_valid_q, win_valid_d;
    logic [9*DATA_W-1:0]  win_q, win_d;

    logic [DATA_W-1:0]    ram1_rd;
    logic [DATA_W-1:0]    ram2_rd;
    logic                 xfer;
    logic                 start_ok;
    logic                 cfg_bad;
    logic                 col_last;
    logic                 row_last;
    logic                 win_hit;

    assign cfg_bad  = (cfg_width < W_MIN) || (cfg_width > W_MAX) ||
                      (cfg_height < 16'd3) ||
                      (cfg_stride == 2'd0) || (cfg_stride == 2'd3);
    assign start_ok = (state_q == ST_IDLE) && start;
    assign xfer     = din_valid && din_ready;
    assign col_last = (col_q == width_q - W_ONE);
    assign row_last = (row_q == height_q - 16'd1);
    assign win_hit  = (row_q >= 16'd2) && (col_q >= W_TWO) &&
                      stride_hit(stride_q, row_q[0]) &&
                      stride_hit(stride_q, col_q[0]);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = cfg_bad ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (xfer && col_last && row_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!win_valid_q || win_ready) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        din_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_RUN: begin
                din_ready = !win_valid_q || win_ready;
                busy      = 1'b1;
            end
            ST_DRAIN: begin
                busy = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                din_ready = 1'b0;
            end
        endcase
    end

    // ---------------- configuration and raster counters ----------------
    always_comb begin
        width_d   = width_q;
        height_d  = height_q;
        stride_d  = stride_q;
        cfg_err_d = cfg_err_q;
        col_d     = col_q;
        row_d     = row_q;
        if (start_ok) begin
            width_d   = cfg_width;
            height_d  = cfg_height;
            stride_d  = cfg_stride;
            cfg_err_d = cfg_bad;
            col_d     = '0;
            row_d     = '0;
        end else if (xfer) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_q + 16'd1;
            end else begin
                col_d = col_q + W_ONE;
            end
        end
    end

    // ---------------- 3x3 window shift register ----------------
    always_comb begin
        win_d       = win_q;
        win_valid_d = win_valid_q;
        if (win_ready) begin
            win_valid_d = 1'b0;
        end
        if (xfer) begin
            for (int r = 0; r < 3; r++) begin
                win_d[DATA_W*(3*r)   +: DATA_W] = win_q[DATA_W*(3*r+1) +: DATA_W];
                win_d[DATA_W*(3*r+1) +: DATA_W] = win_q[DATA_W*(3*r+2) +: DATA_W];
            end
            win_d[DATA_W*2 +: DATA_W] = ram2_rd;
            win_d[DATA_W*5 +: DATA_W] = ram1_rd;
            win_d[DATA_W*8 +: DATA_W] = din_data;
            if (win_hit) begin
                win_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width_q     <= '0;
            height_q    <= '0;
            stride_q    <= '0;
            cfg_err_q   <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
            win_q       <= '0;
        end else begin
            width_q     <= width_d;
            height_q    <= height_d;
            stride_q    <= stride_d;
            cfg_err_q   <= cfg_err_d;
            col_q       <= col_d;
            row_q       <= row_d;
            win_valid_q <= win_valid_d;
            win_q       <= win_d;
        end
    end

    // Reads are issued at the next column so the old row data is ready on the transfer cycle.
    line_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_W)
    ) u_ram1 (
        .clk_i   (clk),
        .we_i    (xfer),
        .waddr_i (col_q[AW-1:0]),
        .wdata_i (din_data),
        .raddr_i (col_d[AW-1:0]),
        .rdata_o (ram1_rd)
    );

    line_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (MAX_W)
    ) u_ram2 (
        .clk_i   (clk),
        .we_i    (xfer),
        .waddr_i (col_q[AW-1:0]),
        .wdata_i (ram1_rd),
        .raddr_i (col_d[AW-1:0]),
        .rdata_o (ram2_rd)
    );

    assign win_valid = win_valid_q;
    assign win_data  = win_q;
    assign cfg_err   = cfg_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_win_buf.sv
// Bench for win_buf: frames are modelled as pixel arrays, every expected window is queued
// up front and a negedge monitor compares whatever the DUT presents against the queue head.
`timescale 1ns/1ps
module tb_win_buf;
    import fa_pkg::*;

    localparam int DATA_W = 16;
    localparam int MAX_W  = 256;
    localparam int WW     = $clog2(MAX_W + 1);
    localparam int WIN_W  = 9 * DATA_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [WW-1:0]     cfg_width = '0;
    logic [15:0]       cfg_height = '0;
    logic [1:0]        cfg_stride = '0;
    logic              din_valid = 1'b0;
    logic              din_ready;
    logic [DATA_W-1:0] din_data = '0;
    logic              win_valid;
    logic              win_ready = 1'b0;
    logic [WIN_W-1:0]  win_data;
    logic              busy;
    logic              done;
    logic              cfg_err;
    wb_state_e         dbg_state;

    int tests = 0;
    int fails = 0;

    logic [WIN_W-1:0]  exp_q[$];
    logic [DATA_W-1:0] pix[$];

    int cyc = 0;
    int pix_acc = 0;
    int win_got = 0;
    int done_cnt = 0;
    int rdy_cnt = 0;
    int last_hs_cyc = 0;
    int done_cyc = 0;
    int rdy_mode = 0;

    win_buf #(
        .DATA_W (DATA_W),
        .MAX_W  (MAX_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .cfg_stride (cfg_stride),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_data   (din_data),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .win_data   (win_data),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial forever #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "simulation time limit reached");
    end

    // ---------------- checkers ----------------
    task automatic check(input string name, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (din_valid && din_ready) pix_acc++;
            if (din_ready) rdy_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (win_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL win_unexpected: actual=%0h required=none", win_data);
                end else begin
                    check("win_data", win_data, exp_q[0]);
                    if (win_ready) begin
                        void'(exp_q.pop_front());
                        win_got++;
                        last_hs_cyc = cyc;
                    end
                end
            end
        end
    end

    // ---------------- downstream ready driver ----------------
    initial forever begin
        @(posedge clk);
        #1;
        win_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end

    // ---------------- reference model ----------------
    function automatic void build_frame(input int w, input int h, input int dmode, input int base);
        pix.delete();
        for (int i = 0; i < w * h; i++) begin
            pix.push_back((dmode == 0) ? 16'(base + i) : 16'($urandom));
        end
    endfunction

    function automatic int push_model(input int w, input int h, input int s);
        int cnt = 0;
        for (int r0 = 0; r0 + 3 <= h; r0 += s) begin
            for (int c0 = 0; c0 + 3 <= w; c0 += s) begin
                logic [WIN_W-1:0] wv;
                wv = '0;
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        wv[DATA_W*(3*r+c) +: DATA_W] = pix[(r0 + r) * w + c0 + c];
                    end
                end
                exp_q.push_back(wv);
                cnt++;
            end
        end
        return cnt;
    endfunction

    // ---------------- driver tasks (entered and left at posedge+1) ----------------
    task automatic run_frame(input int w, input int h, input int s, input int dmode,
                             input int base, input int vmode, input int abort_after);
        int   npix, i, n, budget, got0, pix0, done0;
        logic acc;
        npix = w * h;
        build_frame(w, h, dmode, base);
        void'(push_model(w, h, s));
        got0  = win_got;
        pix0  = pix_acc;
        done0 = done_cnt;
        cfg_width  = WW'(w);
        cfg_height = 16'(h);
        cfg_stride = 2'(s);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_int("busy_after_start", int'(busy), 1);
        check_int("cfg_err_clear", int'(cfg_err), 0);

        i = 0;
        n = 0;
        budget = npix * 8 + 100;
        while (i < npix && n < budget) begin
            din_valid = (vmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            din_data  = pix[i];
            @(negedge clk);
            acc = din_valid && din_ready;
            @(posedge clk);
            #1;
            if (acc) i++;
            n++;
            if (abort_after > 0 && i == abort_after) break;
        end
        din_valid = 1'b0;
        if (abort_after > 0) return;

        check_int("pix_sent", i, npix);
        if (vmode == 0 && rdy_mode == 0) check_int("full_rate_cycles", n, npix);

        n = 0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (done) begin
                check_int("busy_in_done", int'(busy), 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        check_int("done_pulses", done_cnt - done0, 1);
        check_int("window_count", win_got - got0, ((w - 3) / s + 1) * ((h - 3) / s + 1));
        check_int("exp_q_empty", exp_q.size(), 0);
        check_int("pixels_accepted", pix_acc - pix0, npix);
        check_int("cfg_err_legal", int'(cfg_err), 0);
        if ((w - 3) % s == 0 && (h - 3) % s == 0) begin
            check_int("done_latency", done_cyc - last_hs_cyc, 1);
        end
        exp_q.delete();
    endtask

    task automatic run_illegal(input int w, input int h, input int s);
        int rdy0, pix0, got0, done0;
        rdy0  = rdy_cnt;
        pix0  = pix_acc;
        got0  = win_got;
        done0 = done_cnt;
        cfg_width  = WW'(w);
        cfg_height = 16'(h);
        cfg_stride = 2'(s);
        start     = 1'b1;
        din_valid = 1'b1;
        din_data  = 16'hbeef;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_int("bad_cfg_done", int'(done), 1);
        check_int("bad_cfg_err", int'(cfg_err), 1);
        check_int("bad_cfg_busy", int'(busy), 0);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        din_valid = 1'b0;
        check_int("bad_cfg_err_sticky", int'(cfg_err), 1);
        check_int("bad_cfg_ready_seen", rdy_cnt - rdy0, 0);
        check_int("bad_cfg_pixels", pix_acc - pix0, 0);
        check_int("bad_cfg_windows", win_got - got0, 0);
        check_int("bad_cfg_done_pulses", done_cnt - done0, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_int({tag, "_din_ready"}, int'(din_ready), 0);
        check_int({tag, "_win_valid"}, int'(win_valid), 0);
        check({tag, "_win_data"}, win_data, '0);
        check_int({tag, "_busy"}, int'(busy), 0);
        check_int({tag, "_done"}, int'(done), 0);
        check_int({tag, "_cfg_err"}, int'(cfg_err), 0);
        check_int({tag, "_state"}, int'(dbg_state), int'(ST_IDLE));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_idle_outputs("post_reset");

        // Directed frames: index-valued pixels so corners are easy to reason about.
        rdy_mode = 0;
        run_frame(5, 5, 1, 0, 0, 0, 0);
        run_frame(7, 7, 2, 0, 0, 0, 0);
        rdy_mode = 1;
        run_frame(5, 5, 1, 0, 0, 0, 0);
        rdy_mode = 0;

        // Illegal configurations, including the width just past the line RAM depth.
        run_illegal(2, 5, 1);
        run_illegal(MAX_W + 1, 5, 1);
        run_illegal(5, 2, 1);
        run_illegal(5, 5, 3);
        run_illegal(5, 5, 0);

        // Widest legal frame boundary with a short height.
        run_frame(MAX_W, 3, 1, 1, 0, 0, 0);

        // Reset in the middle of a frame, then a clean rerun.
        run_frame(5, 5, 1, 0, 0, 0, 12);
        check_int("busy_before_reset", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_frame(5, 5, 1, 0, 0, 0, 0);

        // Back-to-back frames with disjoint pixel values.
        run_frame(4, 4, 1, 0, 0, 0, 0);
        run_frame(4, 4, 1, 0, 1000, 0, 0);

        // Randomised frames with random upstream gaps and downstream stalls.
        rdy_mode = 1;
        for (int k = 0; k < 8; k++) begin
            run_frame(int'($urandom_range(3, 12)), int'($urandom_range(3, 8)),
                      int'($urandom_range(1, 2)), 1, 0, 1, 0);
        end
        rdy_mode = 0;

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
